// File: rtl/mem_arbiter.sv
//==============================================================================
// Module   : mem_arbiter
// Brief    : Registered instruction-fetch / data-port arbiter for one shared
//            memory, with access timeout and optional fetch anti-starvation
//            guard (enable with `define MEM_ARB_STARVE_GUARD_EN).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_req,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_data_out,
    output logic                  imem_ready,
    input  logic                  ien_mem_re,
    input  logic                  ien_mem_wr,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [DATA_WIDTH-1:0] dmem_data_out,
    output logic                  dmem_ready,
    output logic                  bus_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  oen_mem_re,
    output logic                  oen_mem_wr,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  mem_ready
);

    localparam int c_TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TLAST = c_TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("mem_arbiter: STARVE_LIMIT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_dmem_use;
    logic                  w_any_req;
    logic                  w_grant_imem;
    logic                  w_starve_hit;
    logic                  w_timeout;
    logic                  r_gnt_imem;
    logic                  r_is_write;
    logic                  r_err;
    logic [c_TW-1:0]       r_tcnt;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_re;
    logic                  r_wr;
    logic                  r_imem_ready;
    logic                  r_dmem_ready;
    logic [DATA_WIDTH-1:0] r_imem_data;
    logic [DATA_WIDTH-1:0] r_dmem_data;

    assign w_dmem_use   = ien_mem_re | ien_mem_wr;
    assign w_any_req    = w_dmem_use | imem_req;
    assign w_grant_imem = imem_req & (~w_dmem_use | w_starve_hit);
    // Fires on the last allowed ACCESS cycle; mem_ready on that same cycle still wins.
    assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_tcnt == c_TLAST) && !mem_ready;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int c_SW = $clog2(STARVE_LIMIT + 1);
    logic [c_SW-1:0] r_starve;

    assign w_starve_hit = (r_starve == c_SW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (r_state == S_IDLE && w_any_req) begin
            if (w_grant_imem || !imem_req) begin
                r_starve <= '0;
            end else if (!w_starve_hit) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end
`else
    assign w_starve_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_state_next = S_ACCESS;
            S_ACCESS: if (mem_ready || w_timeout) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt_imem   <= 1'b0;
            r_is_write   <= 1'b0;
            r_err        <= 1'b0;
            r_tcnt       <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_re         <= 1'b0;
            r_wr         <= 1'b0;
            r_imem_ready <= 1'b0;
            r_dmem_ready <= 1'b0;
            r_imem_data  <= '0;
            r_dmem_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt_imem <= w_grant_imem;
                        r_tcnt     <= '0;
                        if (w_grant_imem) begin
                            r_mem_addr <= imem_addr;
                            r_re       <= 1'b1;
                            r_wr       <= 1'b0;
                            r_is_write <= 1'b0;
                        end else begin
                            r_mem_addr <= dmem_addr;
                            // A write wins over a simultaneous read.
                            if (ien_mem_wr) begin
                                r_mem_wdata <= dmem_wdata;
                                r_re        <= 1'b0;
                                r_wr        <= 1'b1;
                                r_is_write  <= 1'b1;
                            end else begin
                                r_re        <= 1'b1;
                                r_wr        <= 1'b0;
                                r_is_write  <= 1'b0;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (mem_ready || w_timeout) begin
                        r_re  <= 1'b0;
                        r_wr  <= 1'b0;
                        r_err <= !mem_ready;
                        if (r_gnt_imem) begin
                            r_imem_ready <= 1'b1;
                            if (mem_ready) r_imem_data <= data_out;
                        end else begin
                            r_dmem_ready <= 1'b1;
                            if (mem_ready && !r_is_write) r_dmem_data <= data_out;
                        end
                    end
                end
                S_DONE: begin
                    r_imem_ready <= 1'b0;
                    r_dmem_ready <= 1'b0;
                    r_imem_data  <= '0;
                    r_dmem_data  <= '0;
                    r_err        <= 1'b0;
                    r_tcnt       <= '0;
                end
                default: begin
                    r_re <= 1'b0;
                    r_wr <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign oen_mem_re    = r_re;
    assign oen_mem_wr    = r_wr;
    assign imem_ready    = r_imem_ready;
    assign dmem_ready    = r_dmem_ready;
    assign imem_data_out = r_imem_data;
    assign dmem_data_out = r_dmem_data;
    assign bus_err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//==============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int c_AW = 32;
    localparam int c_DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_req;
    logic [c_AW-1:0] imem_addr;
    logic [c_DW-1:0] imem_data_out;
    logic            imem_ready;
    logic            ien_mem_re;
    logic            ien_mem_wr;
    logic [c_AW-1:0] dmem_addr;
    logic [c_DW-1:0] dmem_wdata;
    logic [c_DW-1:0] dmem_data_out;
    logic            dmem_ready;
    logic            bus_err;
    logic [c_AW-1:0] mem_addr;
    logic [c_DW-1:0] mem_wdata;
    logic            oen_mem_re;
    logic            oen_mem_wr;
    logic [c_DW-1:0] data_out;
    logic            mem_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH     (c_AW),
        .DATA_WIDTH     (c_DW),
        .TIMEOUT_CYCLES (8),
        .STARVE_LIMIT   (4)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_data_out (imem_data_out),
        .imem_ready    (imem_ready),
        .ien_mem_re    (ien_mem_re),
        .ien_mem_wr    (ien_mem_wr),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_data_out (dmem_data_out),
        .dmem_ready    (dmem_ready),
        .bus_err       (bus_err),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .oen_mem_re    (oen_mem_re),
        .oen_mem_wr    (oen_mem_wr),
        .data_out      (data_out),
        .mem_ready     (mem_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_re"},    64'(oen_mem_re), 64'd0);
        check_eq({tag, "_wr"},    64'(oen_mem_wr), 64'd0);
        check_eq({tag, "_irdy"},  64'(imem_ready), 64'd0);
        check_eq({tag, "_drdy"},  64'(dmem_ready), 64'd0);
        check_eq({tag, "_idata"}, 64'(imem_data_out), 64'd0);
        check_eq({tag, "_ddata"}, 64'(dmem_data_out), 64'd0);
        check_eq({tag, "_err"},   64'(bus_err), 64'd0);
    endtask

    initial begin
        logic [c_AW-1:0] exp_addr;

        rst = 1'b1; imem_req = 1'b0; imem_addr = '0; ien_mem_re = 1'b0; ien_mem_wr = 1'b0;
        dmem_addr = '0; dmem_wdata = '0; data_out = '0; mem_ready = 1'b0;
        step(); step();
        check_idle_outputs("reset");
        check_eq("reset_addr",  64'(mem_addr), 64'd0);
        check_eq("reset_wdata", 64'(mem_wdata), 64'd0);
        rst = 1'b0;

        // Single fetch, memory answers in the first ACCESS cycle
        imem_req = 1'b1; imem_addr = 32'h100; data_out = 32'hDEADBEEF; mem_ready = 1'b1;
        step();
        check_eq("fetch_grant_re",   64'(oen_mem_re), 64'd1);
        check_eq("fetch_grant_addr", 64'(mem_addr), 64'h100);
        check_eq("fetch_grant_rdy",  64'(imem_ready), 64'd0);
        step();
        check_eq("fetch_rdy",     64'(imem_ready), 64'd1);
        check_eq("fetch_data",    64'(imem_data_out), 64'hDEADBEEF);
        check_eq("fetch_re_drop", 64'(oen_mem_re), 64'd0);
        check_eq("fetch_drdy",    64'(dmem_ready), 64'd0);
        check_eq("fetch_err",     64'(bus_err), 64'd0);
        imem_req = 1'b0; mem_ready = 1'b0;
        step();
        check_idle_outputs("fetch_after");

        // Simultaneous fetch and write: write first, fetch in the next IDLE
        imem_req = 1'b1; imem_addr = 32'h104; ien_mem_wr = 1'b1; dmem_addr = 32'h200;
        dmem_wdata = 32'h12345678; data_out = 32'hCAFEF00D; mem_ready = 1'b1;
        step();
        check_eq("sim_wr",    64'(oen_mem_wr), 64'd1);
        check_eq("sim_re",    64'(oen_mem_re), 64'd0);
        check_eq("sim_addr",  64'(mem_addr), 64'h200);
        check_eq("sim_wdata", 64'(mem_wdata), 64'h12345678);
        step();
        check_eq("sim_drdy",  64'(dmem_ready), 64'd1);
        check_eq("sim_irdy",  64'(imem_ready), 64'd0);
        check_eq("sim_ddata", 64'(dmem_data_out), 64'd0);
        ien_mem_wr = 1'b0;
        step();
        check_idle_outputs("sim_idle");
        step();
        check_eq("sim_f_re",   64'(oen_mem_re), 64'd1);
        check_eq("sim_f_addr", 64'(mem_addr), 64'h104);
        step();
        check_eq("sim_f_rdy",   64'(imem_ready), 64'd1);
        check_eq("sim_f_data",  64'(imem_data_out), 64'hCAFEF00D);
        check_eq("sim_f_ddata", 64'(dmem_data_out), 64'd0);
        imem_req = 1'b0; mem_ready = 1'b0;
        step();

        // Timeout with TIMEOUT_CYCLES=8
        ien_mem_re = 1'b1; dmem_addr = 32'h300; data_out = 32'hFFFFFFFF;
        step();
        check_eq("to_grant_re", 64'(oen_mem_re), 64'd1);
        for (int i = 1; i < 8; i++) begin
            step();
            check_eq($sformatf("to_hold_re_%0d", i), 64'(oen_mem_re), 64'd1);
        end
        step();
        check_eq("to_re_drop", 64'(oen_mem_re), 64'd0);
        check_eq("to_drdy",    64'(dmem_ready), 64'd1);
        check_eq("to_err",     64'(bus_err), 64'd1);
        check_eq("to_data",    64'(dmem_data_out), 64'd0);
        ien_mem_re = 1'b0;
        step();
        check_idle_outputs("to_after");

        // Reset in the middle of an access
        imem_req = 1'b1; imem_addr = 32'h180;
        step();
        check_eq("rst_grant_re", 64'(oen_mem_re), 64'd1);
        step();
        rst = 1'b1;
        step();
        check_idle_outputs("rst_mid");
        check_eq("rst_mid_addr", 64'(mem_addr), 64'd0);
        rst = 1'b0; imem_req = 1'b0;
        step();
        check_idle_outputs("rst_after");

        // Read/write collision
        ien_mem_re = 1'b1; ien_mem_wr = 1'b1; dmem_addr = 32'h240; dmem_wdata = 32'hA5A5A5A5;
        data_out = 32'h11112222; mem_ready = 1'b1;
        step();
        check_eq("col_wr",    64'(oen_mem_wr), 64'd1);
        check_eq("col_re",    64'(oen_mem_re), 64'd0);
        check_eq("col_wdata", 64'(mem_wdata), 64'hA5A5A5A5);
        step();
        check_eq("col_drdy",  64'(dmem_ready), 64'd1);
        check_eq("col_ddata", 64'(dmem_data_out), 64'd0);
        ien_mem_re = 1'b0; ien_mem_wr = 1'b0; mem_ready = 1'b0;
        step();
        check_idle_outputs("col_after");
        step();
        check_idle_outputs("col_single");

        // Continuous dmem reads with a pending fetch
        imem_req = 1'b1; imem_addr = 32'h400; ien_mem_re = 1'b1; dmem_addr = 32'h500;
        data_out = 32'h55AA55AA; mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_addr = 32'h500;
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (k == 4) exp_addr = 32'h400;
`endif
            step();
            check_eq($sformatf("starve_addr_%0d", k), 64'(mem_addr), 64'(exp_addr));
            step();
            check_eq($sformatf("starve_irdy_%0d", k), 64'(imem_ready), 64'(exp_addr == 32'h400));
            step();
        end
        imem_req = 1'b0; ien_mem_re = 1'b0; mem_ready = 1'b0;
        step();
        check_idle_outputs("starve_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
